requant_param_loader: RTL and testbench

Writer side of the requantizer parameter store. It accepts a 32-bit host word stream and packs it into 512-bit M entries (16 × int32) and 128-bit EXP entries (16 × int8). It drives the M and EXP DFRAM write ports (`m_wr_*`, `e_wr_*`) of `requantize16_top` at consecutive entry addresses. It sits between the host DMA/config bus and the requantizer, and replaces direct host writes into the two DFRAMs.

---
 rtl/requant_pkg.sv | 20 ++
 rtl/requant_param_loader_word_packer.sv | 51 +++++
 rtl/requant_param_loader.sv | 173 +++++++++++++++++
 tb/tb_requant_param_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// Shared types and constants for the requantizer parameter loader.
package requant_pkg;

    localparam int PLOAD_LANES = 16;
    localparam int PLOAD_SW    = 32;
    localparam int M_WORDS     = PLOAD_LANES * 32 / PLOAD_SW;
    localparam int E_WORDS     = PLOAD_LANES * 8 / PLOAD_SW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_M = 2'd1,
        LOAD_E = 2'd2,
        FIN    = 2'd3
    } pload_state_t;

    function automatic int cnt_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/requant_param_loader_word_packer.sv
// Shifts SW-bit words into an OUT_W-bit entry, first word at the LSB; on the
// completing word it copies the entry to a holding output and pulses full.
module word_packer
    import requant_pkg::*;
#(
    parameter int OUT_W = 512,
    parameter int SW    = 32,
    parameter int WORDS = OUT_W / SW,
    parameter int CW    = cnt_w(OUT_W / SW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift,
    input  logic [SW-1:0]    din,
    output logic [OUT_W-1:0] data,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [OUT_W-1:0] shreg_q;
    logic [OUT_W-1:0] shreg_d;
    logic             last;

    assign shreg_d = {din, shreg_q[OUT_W-1:SW]};
    assign last    = (count == CW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            data    <= '0;
            count   <= '0;
            full    <= 1'b0;
        end else begin
            full <= 1'b0;
            if (clear) begin
                count <= '0;
            end else if (shift) begin
                shreg_q <= shreg_d;
                if (last) begin
                    count <= '0;
                    data  <= shreg_d;
                    full  <= 1'b1;
                end else begin
                    count <= count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/requant_param_loader.sv
// Packs a 32-bit host stream into M (16 x int32) and EXP (16 x int8) DFRAM entries.
// Define PLOAD_CKSUM_EN to build the running XOR checksum of accepted words.
module requant_param_loader
    import requant_pkg::*;
#(
    parameter int LANES = PLOAD_LANES,
    parameter int DEPTH = 131072,
    parameter int AW    = $clog2(DEPTH),
    parameter int SW    = PLOAD_SW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW:0]          num_entries,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [SW-1:0]        s_data,
    input  logic                 s_last,
    output logic                 m_wr_en,
    output logic [AW-1:0]        m_wr_addr,
    output logic [LANES*32-1:0]  m_wr_data,
    output logic                 e_wr_en,
    output logic [AW-1:0]        e_wr_addr,
    output logic [LANES*8-1:0]   e_wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [31:0]          cksum
);

    // state  | meaning
    // IDLE   | waiting for start
    // LOAD_M | collecting the 16 int32 words of an M entry
    // LOAD_E | collecting the packed int8 words of an EXP entry
    // FIN    | load over; done is registered from this state
    localparam int M_W   = LANES * 32;
    localparam int E_W   = LANES * 8;
    localparam int M_CW  = cnt_w(M_W / SW);
    localparam int E_CW  = cnt_w(E_W / SW);

    pload_state_t state_q, state_d;

    logic [AW-1:0] addr_q;
    logic [AW:0]   remaining_q;
    logic [M_CW-1:0] m_count;
    logic [E_CW-1:0] e_count;

    logic accept, start_acc, last_entry, final_word, frame_err;
    logic m_last, e_last, m_shift, e_shift, m_done, e_done, pack_clear;

    assign s_ready    = (state_q == LOAD_M) || (state_q == LOAD_E);
    assign busy       = (state_q != IDLE);
    assign accept     = s_valid && s_ready;
    assign start_acc  = (state_q == IDLE) && start;
    assign last_entry = (remaining_q == (AW+1)'(1));
    assign m_last     = (m_count == M_CW'(M_W / SW - 1));
    assign e_last     = (e_count == E_CW'(E_W / SW - 1));
    assign final_word = (state_q == LOAD_E) && e_last && last_entry;
    // An early s_last drops the entry in progress, so its word is not shifted.
    assign frame_err  = accept && s_last && !final_word;
    assign m_shift    = accept && (state_q == LOAD_M) && !frame_err;
    assign e_shift    = accept && (state_q == LOAD_E) && !frame_err;
    assign m_done     = m_shift && m_last;
    assign e_done     = e_shift && e_last;
    assign pack_clear = (state_q == IDLE) || frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_entries != '0) ? LOAD_M : FIN;
                end
            end
            LOAD_M: begin
                if (frame_err) begin
                    state_d = FIN;
                end else if (m_done) begin
                    state_d = LOAD_E;
                end
            end
            LOAD_E: begin
                if (frame_err || (e_done && last_entry)) begin
                    state_d = FIN;
                end else if (e_done) begin
                    state_d = LOAD_M;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            m_wr_addr   <= '0;
            e_wr_addr   <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= (state_q == FIN);
            if (start_acc) begin
                addr_q      <= base_addr;
                remaining_q <= num_entries;
                err         <= 1'b0;
            end else begin
                if (m_done) begin
                    m_wr_addr <= addr_q;
                end
                if (e_done) begin
                    e_wr_addr   <= addr_q;
                    addr_q      <= (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
                    remaining_q <= remaining_q - 1'b1;
                end
                if (frame_err || (accept && final_word && !s_last)) begin
                    err <= 1'b1;
                end
            end
        end
    end

    word_packer #(.OUT_W(M_W), .SW(SW)) u_m_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (pack_clear),
        .shift (m_shift),
        .din   (s_data),
        .data  (m_wr_data),
        .count (m_count),
        .full  (m_wr_en)
    );

    word_packer #(.OUT_W(E_W), .SW(SW)) u_e_packer (
        .clk   (clk),
        .rst   (rst),
        .clear (pack_clear),
        .shift (e_shift),
        .din   (s_data),
        .data  (e_wr_data),
        .count (e_count),
        .full  (e_wr_en)
    );

`ifdef PLOAD_CKSUM_EN
    logic [31:0] cksum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cksum_q <= '0;
        end else if (start_acc) begin
            cksum_q <= '0;
        end else if (accept) begin
            cksum_q <= cksum_q ^ 32'(s_data);
        end
    end

    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

endmodule

// File: tb/tb_requant_param_loader.sv
// Scoreboard bench for requant_param_loader: directed loads, monitor checks every write and done.
module tb_requant_param_loader;
    import requant_pkg::*;

    localparam int DEPTH = 131072;
    localparam int AW    = 17;
    localparam int NW    = M_WORDS + E_WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   num_entries = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [31:0]   s_data = '0;
    logic          s_last = 1'b0;
    logic          m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [511:0]  m_wr_data;
    logic          e_wr_en;
    logic [AW-1:0] e_wr_addr;
    logic [127:0]  e_wr_data;
    logic          busy, done, err;
    logic [31:0]   cksum;

    requant_param_loader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_entries(num_entries), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_wr_en(m_wr_en), .m_wr_addr(m_wr_addr),
        .m_wr_data(m_wr_data), .e_wr_en(e_wr_en), .e_wr_addr(e_wr_addr),
        .e_wr_data(e_wr_data), .busy(busy), .done(done), .err(err), .cksum(cksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [511:0]  data;
    } wr_exp_t;

    wr_exp_t     m_q[$];
    wr_exp_t     e_q[$];
    logic        d_q[$];
    wr_exp_t     mx, ex;
    logic        dx;
    logic [31:0] wbuf[NW];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          saw_ready = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (s_ready) saw_ready = 1'b1;
        if (!rst) begin
            if (m_wr_en) begin
                if (m_q.size() == 0) begin
                    check("m_unexpected_write", 1'b1, 1'b0);
                end else begin
                    mx = m_q.pop_front();
                    check("m_wr_addr", 512'(m_wr_addr), 512'(mx.addr));
                    check("m_wr_data", m_wr_data, mx.data);
                end
            end
            if (e_wr_en) begin
                if (e_q.size() == 0) begin
                    check("e_unexpected_write", 1'b1, 1'b0);
                end else begin
                    ex = e_q.pop_front();
                    check("e_wr_addr", 512'(e_wr_addr), 512'(ex.addr));
                    check("e_wr_data", 512'(e_wr_data), ex.data);
                end
            end
            if (done) begin
                if (d_q.size() == 0) begin
                    check("unexpected_done", 1'b1, 1'b0);
                end else begin
                    dx = d_q.pop_front();
                    check("err_at_done", 512'(err), 512'(dx));
                end
            end
        end
    end

    // Expected M/EXP entries for wbuf: word k lands at bits [32k+31:32k].
    task automatic push_entry(input logic [AW-1:0] a);
        wr_exp_t m, e;
        m.addr = a;
        m.data = '0;
        e.addr = a;
        e.data = '0;
        for (int k = 0; k < M_WORDS; k++) m.data[32*k +: 32] = wbuf[k];
        for (int k = 0; k < E_WORDS; k++) e.data[32*k +: 32] = wbuf[M_WORDS + k];
        m_q.push_back(m);
        e_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] w, input logic last, input bit stall);
        int n;
        bit got;
        if (stall && ($urandom_range(0, 1) == 1)) begin
            s_valid = 1'b0;
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = w;
        s_last  = last;
        n = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(negedge clk);
            got = s_ready;
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!got) check("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic send_entry(input bit final_entry, input bit stall);
        for (int k = 0; k < NW; k++) send(wbuf[k], final_entry && (k == NW - 1), stall);
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
        start       = 1'b1;
        base_addr   = b;
        num_entries = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = done;
            n++;
        end
        if (!got) check(name, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] ew[4];
        ew[0] = 32'h04030201; ew[1] = 32'h08070605;
        ew[2] = 32'h0C0B0A09; ew[3] = 32'h100F0E0D;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_s_ready", 512'(s_ready), 512'(0));
        check("rst_strobes", 512'({m_wr_en, e_wr_en, done, err}), 512'(0));
        check("rst_m_data", m_wr_data, 512'(0));
        check("rst_addrs", 512'({m_wr_addr, e_wr_addr}), 512'(0));
        check("rst_e_data_cksum", 512'({e_wr_data, cksum}), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Single entry at address 5, lane i = i+1 in both RAMs
        for (int k = 0; k < M_WORDS; k++) wbuf[k] = 32'(k + 1);
        for (int k = 0; k < E_WORDS; k++) wbuf[M_WORDS + k] = ew[k];
        push_entry(AW'(5));
        check("t1_e_expect", e_q[0].data, 512'(128'h100F0E0D_0C0B0A09_08070605_04030201));
        d_q.push_back(1'b0);
        do_start(AW'(5), (AW+1)'(1));
        send_entry(1'b1, 1'b0);
        @(negedge clk);
        check("t1_e_wr_en", 512'(e_wr_en), 512'(1));
        check("t1_done_early", 512'(done), 512'(0));
        @(negedge clk);
        check("t1_done", 512'(done), 512'(1));
        check("t1_busy", 512'(busy), 512'(0));
        check("t1_err", 512'(err), 512'(0));
        @(posedge clk); #1;

        // Three entries wrapping past DEPTH-1 with stalls
        d_q.push_back(1'b0);
        do_start(AW'(DEPTH - 2), (AW+1)'(3));
        for (int e = 0; e < 3; e++) begin
            for (int k = 0; k < NW; k++) wbuf[k] = $urandom;
            push_entry(AW'((DEPTH - 2 + e) % DEPTH));
            send_entry(e == 2, 1'b1);
        end
        wait_done("t2_done_timeout");
        @(posedge clk); #1;

        // Zero entries: straight to FIN, done two cycles after start
        saw_ready = 1'b0;
        d_q.push_back(1'b0);
        do_start(AW'(7), '0);
        @(negedge clk);
        check("t3_done_early", 512'(done), 512'(0));
        @(negedge clk);
        check("t3_done", 512'(done), 512'(1));
        repeat (3) @(negedge clk);
        check("t3_no_ready", 512'(saw_ready), 512'(0));
        @(posedge clk); #1;

        // Early s_last on word 10 of entry 0
        d_q.push_back(1'b1);
        do_start(AW'(40), (AW+1)'(2));
        for (int k = 0; k < 10; k++) send(32'hC000_0000 + 32'(k), k == 9, 1'b0);
        wait_done("t4_done_timeout");
        @(negedge clk);
        check("t4_err_sticky", 512'(err), 512'(1));
        @(posedge clk); #1;

        // Reset after 25 words of a 2-entry load
        for (int k = 0; k < NW; k++) wbuf[k] = 32'hD000_0000 + 32'(k);
        push_entry(AW'(100));
        do_start(AW'(100), (AW+1)'(2));
        send_entry(1'b0, 1'b0);
        for (int k = 0; k < 5; k++) send(32'hEEEE_0000 + 32'(k), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_busy", 512'(busy), 512'(0));
        check("t5_strobes", 512'({m_wr_en, e_wr_en, done, err, s_ready}), 512'(0));
        check("t5_m_data", m_wr_data, 512'(0));
        check("t5_e_data_addrs", 512'({e_wr_data, m_wr_addr, e_wr_addr}), 512'(0));
        repeat (5) @(negedge clk);
        @(posedge clk); #1;

        // Checksum of A5A5A5A5, 5A5A5A5A and 18 zero words
        for (int k = 0; k < NW; k++) wbuf[k] = 32'h0;
        wbuf[0] = 32'hA5A5A5A5;
        wbuf[1] = 32'h5A5A5A5A;
        push_entry(AW'(12'h200));
        d_q.push_back(1'b0);
        do_start(AW'(12'h200), (AW+1)'(1));
        send_entry(1'b1, 1'b0);
        wait_done("t6_done_timeout");
`ifdef PLOAD_CKSUM_EN
        check("t6_cksum", 512'(cksum), 512'(32'hFFFFFFFF));
`else
        check("t6_cksum_off", 512'(cksum), 512'(0));
`endif
        repeat (3) @(posedge clk);
        #1;

        check("m_queue_drained", 512'(m_q.size()), 512'(0));
        check("e_queue_drained", 512'(e_q.size()), 512'(0));
        check("done_queue_drained", 512'(d_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
